// File: rtl/mul_sequencer_if.sv
// Handshake and data bundle between the EX-stage decode/result mux and the
// iterative multiplier.
interface mul_sequencer_if #(
  parameter int unsigned DATA_W = 32
);

  logic              start;
  logic              flush;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;
  logic              done;
  logic              busy;
  logic              stall;

  // Pipeline side: issues the MUL and consumes the product / stall.
  modport master (
    output start, flush, op_a, op_b,
    input  result, done, busy, stall
  );

  // Multiplier side.
  modport slave (
    input  start, flush, op_a, op_b,
    output result, done, busy, stall
  );

endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage. Accepts a MUL from IDLE,
// iterates once per bit of the multiplier, then presents the low word of the
// product for one DONE cycle. Latency is fixed at DATA_W+1 cycles from accept.
module mul_sequencer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic            clk,
  input  logic            arst_n,
  mul_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mcand_nx;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] mplier_nx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic              stall_c;

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath registers; a flush leaves them untouched so result keeps the
  // partial accumulator until the next accept.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
    end
  end

  // Next-state, datapath update and combinational stall.
  always_comb begin
    state_nx  = state;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    acc_nx    = acc;
    cnt_nx    = cnt;
    stall_c   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_nx  = S_RUN;
          mcand_nx  = bus.op_a;
          mplier_nx = bus.op_b;
          acc_nx    = '0;
          cnt_nx    = '0;
          stall_c   = 1'b1;
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          state_nx = S_IDLE;
        end else begin
          stall_c = 1'b1;
          if (mplier[0]) begin
            acc_nx = acc + mcand;
          end
          mcand_nx  = mcand << 1;
          mplier_nx = mplier >> 1;
          cnt_nx    = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_nx = S_DONE;
          end
        end
      end

      // start here is the same instruction leaving EX; flush cannot cancel it.
      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs decoded straight from registers, except the combinational stall.
  assign bus.result = acc;
  assign bus.done   = (state == S_DONE);
  assign bus.busy   = (state == S_RUN);
  assign bus.stall  = stall_c;

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiplier and sequencer for the EX stage. It executes the `MUL_OP` (4'd8) ALU operation over DATA_W+1 cycles, holds the pipeline with a stall signal while it works, and returns the low DATA_W bits of the product with a one-cycle done pulse. It sits beside the ALU. The EX-stage decode drives `start` when the ALU control code is `MUL_OP`, and the result mux selects `result` when `done` is high.

## Interface
- DATA_W, 32: operand and result width. Must be at least 2.
- clk  in  1  clock. All state updates on the rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- start  in  1  EX stage holds a valid MUL instruction. Held high by the pipeline while `stall`=1.
- flush  in  1  squash the EX instruction (branch mispredict or exception). Aborts the multiply.
- op_a  in  DATA_W  multiplicand. Sampled only on the accept edge.
- op_b  in  DATA_W  multiplier. Sampled only on the accept edge.
- result  out  DATA_W  (op_a*op_b) mod 2^DATA_W. Registered.
- done  out  1  single-cycle pulse. `result` is valid during this cycle.
- busy  out  1  high in RUN state.
- stall  out  1  freeze PC, IF/ID, ID/EX. Combinational.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iterating.
  - DONE: one cycle, result presented.
- Registers:
  - state
  - mcand (DATA_W)
  - mplier (DATA_W)
  - acc (DATA_W)
  - cnt ($clog2(DATA_W)+1 bits)
- IDLE, start=1, flush=0 (accept edge):
  - mcand←op_a, mplier←op_b, acc←0, cnt←0.
  - Next state RUN.
- IDLE with start=0 or flush=1: stay in IDLE. No register changes.
- RUN, each edge:
  - If mplier[0]: acc←acc+mcand (wraps mod 2^DATA_W).
  - mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1.
  - On the edge where cnt==DATA_W-1, next state is DONE.
- RUN with flush=1:
  - Next state IDLE. acc, mcand and mplier are left unchanged.
  - `done` is never pulsed for that instruction.
- DONE:
  - Always returns to IDLE on the next edge.
  - `start` is ignored, because it is still the same instruction leaving EX.
  - `flush` in DONE has no effect on the state machine.
- `result` is continuously driven from acc:
  - It holds its value through IDLE until the next accept edge clears acc.
  - It is meaningful only while `done`=1.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - stall = ((state==IDLE)&start&~flush) | ((state==RUN)&~flush).
- No early termination. A zero multiplier still takes the full DATA_W iterations, so latency is deterministic.
- Signedness is irrelevant: the low word is identical for signed and unsigned operands.

## Timing
- Reset (arst_n=0), asynchronous:
  - state=IDLE; mcand, mplier, acc and cnt all 0.
  - result=0, done=0, busy=0. stall=0 unless start is high.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE with no done pulse.
- Latency:
  - Let cycle 0 be the cycle in which `start` is first high in IDLE.
  - `done` and a valid `result` appear in cycle DATA_W+1.
  - That is cycle 33 for DATA_W=32.
- Stall covers cycles 0..DATA_W, which is DATA_W+1 cycles. stall=0 in the DONE cycle, so the MUL instruction advances at the end of it.
- Back-to-back MULs:
  - The second MUL enters EX after DONE and is seen in IDLE in cycle DATA_W+2.
  - That gives one bubble-free restart, with `done` pulses spaced DATA_W+2 cycles apart.
- `flush` is combinational into stall: the flush cycle never stalls.
- `op_a` and `op_b` may change after the accept edge without affecting the result.

## Test plan
- Basic product:
  - Stimulus: reset, then start with op_a=3, op_b=5 held until done.
  - Required: stall=1 in cycles 0..32; done=1 only in cycle 33 with result=15; cycle 34 in IDLE with done=0.
- Wrap-around:
  - Stimulus: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF.
  - Required: result=0x00000001 at done.
  - Stimulus: op_a=0x80000000, op_b=2.
  - Required: result=0.
- Back-to-back:
  - Stimulus: MUL 7×6, then MUL 0x10000×0x10000, with start continuously high.
  - Required: first done in cycle 33 with result=42; second done in cycle 67 with result=0; start ignored in DONE.
- Flush mid-run:
  - Stimulus: start 9×9, then flush=1 in cycle 10.
  - Required: stall=0 in cycle 10; IDLE in cycle 11; no done pulse.
  - Follow-up: a new MUL 2×2 then yields done with result=4 exactly 33 cycles after its start.
- Async reset mid-run:
  - Stimulus: drop arst_n in cycle 15, between clock edges.
  - Required: busy, done and stall (start=0) go low immediately; result=0.
  - Follow-up: after release, a MUL 1×1 completes normally with result=1.
- Operand hold:
  - Stimulus: change op_a and op_b every cycle after the accept edge of 12×12.
  - Required: result=144 at done.
